// File: rtl/updown_count_tracker_pkg.sv
// updown_count_tracker_pkg: shared state encoding, direction and step-delta constants
package updown_count_tracker_pkg;
  typedef enum logic [1:0] {SYNC = 2'd0, TRACK = 2'd1, LOST = 2'd2} state_t;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;
  localparam logic [1:0] STEP_UP = 2'd1;
  localparam logic [1:0] STEP_DN = 2'd3;
endpackage

// File: rtl/updown_count_tracker_if.sv
// updown_count_tracker_if: counter-side signals and tracker results between counter monitor and consumer
interface updown_count_tracker_if #(
  parameter int POS_W = 8,
  parameter int ERR_W = 4
);
  logic [1:0] cnt_q;
  logic up_down;
  logic [POS_W-1:0] pos;
  logic wrap_up;
  logic wrap_dn;
  logic step_err;
  logic [ERR_W-1:0] err_cnt;
  logic locked;
  modport master(output cnt_q, up_down, input pos, wrap_up, wrap_dn, step_err, err_cnt, locked);
  modport slave(input cnt_q, up_down, output pos, wrap_up, wrap_dn, step_err, err_cnt, locked);
endinterface

// File: rtl/updown_count_tracker_step_classifier.sv
// step_classifier: judges one counter step against the direction it was commanded with
module step_classifier
  import updown_count_tracker_pkg::*;
(
  input  logic [1:0] prev,
  input  logic [1:0] cnt_q,
  input  logic       dir_d,
  output logic       good,
  output logic       wrap_up,
  output logic       wrap_dn
);
  logic [1:0] delta;
  // delta is modulo 4, so a down step reads as 3
  always_comb begin
    delta   = cnt_q - prev;
    good    = (dir_d == DIR_UP) ? (delta == STEP_UP) : (delta == STEP_DN);
    wrap_up = good && dir_d == DIR_UP && prev == 2'd3 && cnt_q == 2'd0;
    wrap_dn = good && dir_d == DIR_DN && prev == 2'd0 && cnt_q == 2'd3;
  end
endmodule

// File: rtl/updown_count_tracker.sv
// updown_count_tracker: checks JK up/down counter steps and extends them into a signed position (err_cnt enabled by TRACKER_ERR_CNT_EN)
module updown_count_tracker
  import updown_count_tracker_pkg::*;
#(
  parameter int POS_W     = 8,
  parameter int ERR_W     = 4,
  parameter int ERR_LIMIT = 2,
  parameter int RELOCK_N  = 4
) (
  input logic clk,
  input logic rst,
  updown_count_tracker_if.slave bus
);
  localparam int BW = $clog2(ERR_LIMIT + 1);
  localparam int GW = $clog2(RELOCK_N + 1);
  state_t state, next_state;
  logic [1:0] prev;
  logic dir_d;
  logic good, cls_wrap_up, cls_wrap_dn, chk, bad;
  logic [BW-1:0] bad_run;
  logic [GW-1:0] good_run;
  logic [POS_W-1:0] pos_r;
  logic wrap_up_r, wrap_dn_r, step_err_r;

  step_classifier u_cls (
    .prev   (prev),
    .cnt_q  (bus.cnt_q),
    .dir_d  (dir_d),
    .good   (good),
    .wrap_up(cls_wrap_up),
    .wrap_dn(cls_wrap_dn)
  );

  // lock state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= SYNC;
    else state <= next_state;

  // SYNC primes once; TRACK drops after ERR_LIMIT bad steps; LOST relocks after RELOCK_N good steps
  always_comb begin
    chk = state == TRACK || state == LOST;
    bad = chk && !good;
    next_state = state == SYNC  ? TRACK :
                 state == TRACK ? ((bad && bad_run == BW'(ERR_LIMIT - 1)) ? LOST : TRACK) :
                 state == LOST  ? ((good && good_run == GW'(RELOCK_N - 1)) ? TRACK : LOST) :
                 SYNC;
  end

  // step history, position, event pulses and run counters
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      prev       <= '0;
      dir_d      <= 1'b0;
      pos_r      <= '0;
      wrap_up_r  <= 1'b0;
      wrap_dn_r  <= 1'b0;
      step_err_r <= 1'b0;
      bad_run    <= '0;
      good_run   <= '0;
    end else begin
      prev       <= bus.cnt_q;
      dir_d      <= bus.up_down;
      wrap_up_r  <= state == TRACK && cls_wrap_up;
      wrap_dn_r  <= state == TRACK && cls_wrap_dn;
      step_err_r <= bad;
      if (state == TRACK && good) pos_r <= (dir_d == DIR_UP) ? pos_r + POS_W'(1) : pos_r - POS_W'(1);
      bad_run    <= (state == TRACK && bad && next_state == TRACK) ? bad_run + BW'(1) : '0;
      good_run   <= (state == LOST && good && next_state == LOST) ? good_run + GW'(1) : '0;
    end

`ifdef TRACKER_ERR_CNT_EN
  logic [ERR_W-1:0] err_q;
  // saturating count of every illegal step seen outside SYNC
  always_ff @(posedge clk or posedge rst)
    if (rst) err_q <= '0;
    else if (bad && err_q != '1) err_q <= err_q + ERR_W'(1);
  assign bus.err_cnt = err_q;
`else
  assign bus.err_cnt = ERR_W'(0);
`endif

  assign bus.pos      = pos_r;
  assign bus.wrap_up  = wrap_up_r;
  assign bus.wrap_dn  = wrap_dn_r;
  assign bus.step_err = step_err_r;
  assign bus.locked   = state == TRACK;
endmodule
